// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// One operation at a time. Round-robin priority between the ports.
// Opcode 4'b1011 is illegal: it is accepted, never sent to the ALU, and it
// returns r=0, z=1, err=1.
module alu_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_aluc,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_aluc,
  output logic        req1_ready,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_r,
  output logic        resp_z,
  output logic        resp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z
);

  localparam logic [3:0] IllegalOp = 4'b1011;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        prio_q, owner_q, err_q;
  logic [31:0] a_q, b_q;
  logic [3:0]  aluc_q;
  logic [31:0] resp_r_q;
  logic        resp_z_q, resp_err_q;

  logic        grant_valid, grant_port, accept, resp_done, sel_illegal;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_aluc;

  // Grant selection and operand mux for the port that would win in IDLE
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_port = prio_q;
    end else begin
      grant_port = req1_valid;
    end
    sel_a       = grant_port ? req1_a    : req0_a;
    sel_b       = grant_port ? req1_b    : req0_b;
    sel_aluc    = grant_port ? req1_aluc : req0_aluc;
    sel_illegal = (sel_aluc == IllegalOp);
    // rst_n gating keeps ready low while reset is held with a valid request
    accept      = rst_n && (state_q == StIdle) && grant_valid;
    resp_done   = (state_q == StResp) && (owner_q ? resp1_ready : resp0_ready);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req0_ready  = accept && !grant_port;
    req1_ready  = accept && grant_port;
    resp0_valid = (state_q == StResp) && !owner_q;
    resp1_valid = (state_q == StResp) && owner_q;
  end

  // Operand capture, result capture and priority rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= PRIO_INIT;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      aluc_q     <= '0;
      resp_r_q   <= '0;
      resp_z_q   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= grant_port;
        err_q   <= sel_illegal;
        // Illegal opcodes are replaced by a harmless all-zero operation
        a_q     <= sel_illegal ? 32'h0 : sel_a;
        b_q     <= sel_illegal ? 32'h0 : sel_b;
        aluc_q  <= sel_illegal ? 4'h0  : sel_aluc;
      end
      if (state_q == StExec) begin
        resp_r_q   <= err_q ? 32'h0 : alu_r;
        resp_z_q   <= err_q ? 1'b1  : alu_z;
        resp_err_q <= err_q;
      end
      if (resp_done) begin
        prio_q <= ~owner_q;
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_aluc = aluc_q;
  assign resp_r   = resp_r_q;
  assign resp_z   = resp_z_q;
  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. The bench plays the ALU with a small model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_aluc, req1_aluc;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_r;
  logic        resp_z, resp_err;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        alu_z;

  int checks = 0;
  int errors = 0;
  logic bad_aluc = 1'b0;

  alu_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_aluc(req0_aluc), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_aluc(req1_aluc), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_r(resp_r), .resp_z(resp_z), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // ALU model: 0000 add, 0100 sub, 0010 xor, 0110 lui, 0111 srl, 1111 sra
  always_comb begin
    case (alu_aluc)
      4'b0000: alu_r = alu_a + alu_b;
      4'b0100: alu_r = alu_a - alu_b;
      4'b0010: alu_r = alu_a ^ alu_b;
      4'b0110: alu_r = {alu_b[15:0], 16'h0000};
      4'b0111: alu_r = alu_b >> alu_a[4:0];
      4'b1111: alu_r = $signed(alu_b) >>> alu_a[4:0];
      default: alu_r = alu_a & alu_b;
    endcase
    alu_z = (alu_r == 32'h0);
  end

  always @(posedge clk or negedge clk) begin
    if (alu_aluc === 4'b1011) bad_aluc = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic port, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] aluc);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = aluc;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = aluc;
    end
  endtask

  // Called just after a negedge; runs one op and checks latency and result
  task automatic run_op(input string tag, input logic port, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] aluc,
                        input logic [31:0] exp_r, input logic exp_z, input logic exp_err);
    logic got;
    int   n;
    drive_req(port, a, b, aluc);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) got = 1'b1;
      else @(negedge clk);
    end
    check_eq({tag, "_grant"}, {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (port ? resp1_valid : resp0_valid) got = 1'b1;
    end
    check_eq({tag, "_latency"}, n, 2);
    check_eq({tag, "_r"}, resp_r, exp_r);
    check_eq({tag, "_z"}, {31'b0, resp_z}, {31'b0, exp_z});
    check_eq({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    check_eq({tag, "_other_valid"}, {31'b0, port ? resp0_valid : resp1_valid}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int grants[$];

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 4'h0;
    req1_a = '0; req1_b = '0; req1_aluc = 4'h0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Reset state, with a request pending that must not be acknowledged
    #12;
    check_eq("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check_eq("rst_resp_valid", {30'b0, resp0_valid, resp1_valid}, 32'd0);
    check_eq("rst_resp_r", resp_r, 32'd0);
    check_eq("rst_flags", {30'b0, resp_z, resp_err}, 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single add
    run_op("add", 1'b0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b0);
    @(posedge clk);

    // Contention from a fresh reset: grants must alternate starting with port 0
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_aluc = 4'b0100;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'h0000_ABCD; req1_aluc = 4'b0110;
    for (int c = 0; c < 14; c++) begin
      #1;
      check_eq("cont_one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp0_valid) begin
        check_eq("cont_p0_r", resp_r, 32'd0);
        check_eq("cont_p0_z", {31'b0, resp_z}, 32'd1);
      end
      if (resp1_valid) check_eq("cont_p1_r", resp_r, 32'hABCD_0000);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("cont_ngrants", grants.size(), 5);
    for (int g = 0; g < grants.size(); g++) check_eq("cont_order", grants[g], g % 2);
    repeat (4) @(negedge clk);

    // Back-pressure on port 1 xor
    resp1_ready = 1'b0;
    run_op("xor", 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0010, 32'hF0F0_0F0F, 1'b0, 1'b0);
    drive_req(1'b0, 32'd1, 32'd1, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check_eq("bp_valid", {31'b0, resp1_valid}, 32'd1);
      check_eq("bp_r", resp_r, 32'hF0F0_0F0F);
      check_eq("bp_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
    end
    req0_valid = 1'b0;
    resp1_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_released", {31'b0, resp1_valid}, 32'd0);

    // Illegal opcode, then a legal op clears err
    run_op("illegal", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1011, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    run_op("after_illegal", 1'b0, 32'd1, 32'd1, 4'b0000, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("no_aluc_1011", {31'b0, bad_aluc}, 32'd0);

    // Reset during EXEC
    drive_req(1'b0, 32'd3, 32'd4, 4'b0000);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    check_eq("exec_alu_a", alu_a, 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("exec_rst_alu", {alu_a[3:0], alu_b[3:0], alu_aluc}, 32'd0);
    check_eq("exec_rst_resp_r", resp_r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("exec_dropped", {30'b0, resp0_valid, resp1_valid}, 32'd0);
    end

    // Reset during RESP, then first-cycle grant to port 1
    resp0_ready = 1'b0;
    run_op("pre_rst", 1'b0, 32'd10, 32'd20, 4'b0000, 32'd30, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("resp_rst_valid", {31'b0, resp0_valid}, 32'd0);
    check_eq("resp_rst_r", resp_r, 32'd0);
    resp0_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(1'b1, 32'd4, 32'h8000_0000, 4'b1111);
    #1;
    check_eq("first_cycle_grant", {31'b0, req1_ready}, 32'd1);
    run_op("sra", 1'b1, 32'd4, 32'h8000_0000, 4'b1111, 32'hF800_0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("srl", 1'b1, 32'd4, 32'h8000_0000, 4'b0111, 32'h0800_0000, 1'b0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
